pressure_avg_monitor: RTL and testbench

Downstream consumer of the 8-bit ADC converter output in the pressure-sensor datapath. Smooths the converted samples with a sliding-window moving average, publishes the filtered value, and drives a debounced, hysteretic over-pressure alarm from it. Only one clock domain is used; the block runs at the ADC's clock with a per-sample valid strobe.

---
 rtl/pressure_avg_monitor.sv | 138 +++++++++++++
 tb/tb_pressure_avg_monitor.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pressure_avg_monitor.sv
// Sliding-window moving average of 8-bit pressure samples with a debounced,
// hysteretic over-pressure alarm driven from each full-window average.
module pressure_avg_monitor #(
   parameter int unsigned LOG2_N    = 3,
   parameter int unsigned HI_THRESH = 200,
   parameter int unsigned LO_THRESH = 180,
   parameter int unsigned DEBOUNCE  = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] sample_in,
   input  logic       sample_valid,
   output logic [7:0] avg_out,
   output logic       avg_valid,
   output logic       window_full,
   output logic       over_pressure
);

   localparam int unsigned N    = 1 << LOG2_N;
   localparam int unsigned SumW = 8 + LOG2_N;

   localparam logic [LOG2_N:0] FillMax = (LOG2_N + 1)'(N);
   localparam logic [7:0]      HiTh    = 8'(HI_THRESH);
   localparam logic [7:0]      LoTh    = 8'(LO_THRESH);
   localparam logic [3:0]      DebCnt  = 4'(DEBOUNCE);

   typedef enum logic [1:0] {StNormal, StRisePend, StAlarm, StFallPend} state_e;

   logic [7:0]        buf_q [N];
   logic [LOG2_N-1:0] wr_ptr_q;
   logic [LOG2_N:0]   fill_q, fill_d;
   logic [SumW-1:0]   sum_q, sum_d;
   logic [7:0]        avg_q, avg_d, avg_next;
   logic              avg_valid_q, avg_valid_d;
   logic              full_q, full_d;
   logic              op_q, op_d;
   logic              publish;
   state_e            state_q, state_d;
   logic [3:0]        dcnt_q, dcnt_d;

   // Unfilled entries are zero, so subtracting the oldest entry keeps the sum exact while filling.
   always_comb begin
      sum_d  = sum_q;
      fill_d = fill_q;
      if (sample_valid) begin
         sum_d = sum_q + SumW'(sample_in) - SumW'(buf_q[wr_ptr_q]);
         if (fill_q != FillMax) begin
            fill_d = fill_q + 1'b1;
         end
      end
      avg_next    = 8'(sum_d >> LOG2_N);
      publish     = sample_valid && (fill_d == FillMax);
      avg_d       = publish ? avg_next : avg_q;
      avg_valid_d = publish;
      full_d      = full_q | publish;
   end

   always_comb begin
      state_d = state_q;
      dcnt_d  = dcnt_q;
      if (publish) begin
         unique case (state_q)
            StNormal: begin
               if (avg_next >= HiTh) begin
                  dcnt_d  = 4'd1;
                  state_d = (DebCnt == 4'd1) ? StAlarm : StRisePend;
               end
            end
            StRisePend: begin
               if (avg_next >= HiTh) begin
                  dcnt_d = dcnt_q + 4'd1;
                  if (dcnt_d == DebCnt) begin
                     state_d = StAlarm;
                  end
               end else begin
                  dcnt_d  = 4'd0;
                  state_d = StNormal;
               end
            end
            StAlarm: begin
               if (avg_next <= LoTh) begin
                  dcnt_d  = 4'd1;
                  state_d = (DebCnt == 4'd1) ? StNormal : StFallPend;
               end
            end
            StFallPend: begin
               if (avg_next <= LoTh) begin
                  dcnt_d = dcnt_q + 4'd1;
                  if (dcnt_d == DebCnt) begin
                     state_d = StNormal;
                  end
               end else begin
                  dcnt_d  = 4'd0;
                  state_d = StAlarm;
               end
            end
            default: state_d = StNormal;
         endcase
      end
      op_d = (state_d == StAlarm) || (state_d == StFallPend);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < N; i++) begin
            buf_q[i] <= '0;
         end
         wr_ptr_q    <= '0;
         fill_q      <= '0;
         sum_q       <= '0;
         avg_q       <= '0;
         avg_valid_q <= 1'b0;
         full_q      <= 1'b0;
         op_q        <= 1'b0;
         state_q     <= StNormal;
         dcnt_q      <= '0;
      end else begin
         if (sample_valid) begin
            buf_q[wr_ptr_q] <= sample_in;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         fill_q      <= fill_d;
         sum_q       <= sum_d;
         avg_q       <= avg_d;
         avg_valid_q <= avg_valid_d;
         full_q      <= full_d;
         op_q        <= op_d;
         state_q     <= state_d;
         dcnt_q      <= dcnt_d;
      end
   end

   assign avg_out       = avg_q;
   assign avg_valid     = avg_valid_q;
   assign window_full   = full_q;
   assign over_pressure = op_q;

endmodule

// File: tb/tb_pressure_avg_monitor.sv
// Directed bench for pressure_avg_monitor with a scoreboard of expected outputs per cycle.
module tb_pressure_avg_monitor;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] sample_in = '0;
   logic       sample_valid = 1'b0;
   logic [7:0] avg_out;
   logic       avg_valid;
   logic       window_full;
   logic       over_pressure;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       v;
      logic [7:0] a;
      logic       op;
      logic       wf;
   } exp_t;

   exp_t sb[$];

   // Reference model state
   int win[$];
   int mfill = 0;
   int mst   = 0;  // 0 normal, 1 rise pend, 2 alarm, 3 fall pend
   int mdcnt = 0;
   int mavg  = 0;

   localparam int Hi = 200;
   localparam int Lo = 180;
   localparam int Deb = 4;

   pressure_avg_monitor dut (
      .clk           (clk),
      .reset         (reset),
      .sample_in     (sample_in),
      .sample_valid  (sample_valid),
      .avg_out       (avg_out),
      .avg_valid     (avg_valid),
      .window_full   (window_full),
      .over_pressure (over_pressure)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      win.delete();
      mfill = 0;
      mst   = 0;
      mdcnt = 0;
      mavg  = 0;
   endtask

   task automatic model_tick(input bit v, input int s);
      exp_t e;
      int   sum;
      e.v = 1'b0;
      if (v) begin
         win.push_back(s);
         if (win.size() > 8) void'(win.pop_front());
         if (mfill < 8) mfill++;
         if (mfill == 8) begin
            sum = 0;
            foreach (win[i]) sum += win[i];
            mavg = sum / 8;
            e.v  = 1'b1;
            case (mst)
               0: if (mavg >= Hi) begin mdcnt = 1; mst = (Deb == 1) ? 2 : 1; end
               1: if (mavg >= Hi) begin mdcnt++; if (mdcnt == Deb) mst = 2; end
                  else begin mdcnt = 0; mst = 0; end
               2: if (mavg <= Lo) begin mdcnt = 1; mst = (Deb == 1) ? 0 : 3; end
               default: if (mavg <= Lo) begin mdcnt++; if (mdcnt == Deb) mst = 0; end
                  else begin mdcnt = 0; mst = 2; end
            endcase
         end
      end
      e.a  = 8'(mavg);
      e.op = (mst >= 2);
      e.wf = (mfill == 8);
      sb.push_back(e);
   endtask

   // One clock: drive, push expectation, then compare after the edge.
   task automatic tick(input bit v, input int s, input string tag);
      exp_t e;
      sample_valid = v;
      sample_in    = 8'(s);
      model_tick(v, s);
      @(posedge clk);
      #1;
      sample_valid = 1'b0;
      checks++;
      assert (sb.size() > 0) else begin
         errors++;
         $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
      end
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk({tag, ".valid"}, 32'(avg_valid), 32'(e.v));
         chk({tag, ".avg"}, 32'(avg_out), 32'(e.a));
         chk({tag, ".op"}, 32'(over_pressure), 32'(e.op));
         chk({tag, ".wf"}, 32'(window_full), 32'(e.wf));
      end
   endtask

   task automatic do_reset(input bit v, input int s);
      reset        = 1'b1;
      sample_valid = v;
      sample_in    = 8'(s);
      @(posedge clk);
      #1;
      reset        = 1'b0;
      sample_valid = 1'b0;
      model_reset();
      chk("rst.avg", 32'(avg_out), 0);
      chk("rst.valid", 32'(avg_valid), 0);
      chk("rst.wf", 32'(window_full), 0);
      chk("rst.op", 32'(over_pressure), 0);
   endtask

   initial begin
      // Fill
      do_reset(1'b0, 0);
      for (int i = 0; i < 7; i++) tick(1'b1, 100, "fill");
      tick(1'b1, 100, "fill8");
      chk("fill8.avg100", 32'(avg_out), 100);
      chk("fill8.wf", 32'(window_full), 1);
      tick(1'b0, 0, "idle");

      // Slide and wrap
      tick(1'b1, 255, "slide");
      chk("slide.avg119", 32'(avg_out), 119);
      for (int i = 0; i < 7; i++) tick(1'b1, 255, "wrap");
      chk("wrap.avg255", 32'(avg_out), 255);

      // Alarm set
      do_reset(1'b0, 0);
      for (int i = 1; i <= 10; i++) tick(1'b1, 210, "rise");
      chk("rise.s10.op", 32'(over_pressure), 0);
      tick(1'b1, 210, "rise11");
      chk("rise.s11.op", 32'(over_pressure), 1);

      // Debounce reject: averages 205,205,205,199,205,205,205
      do_reset(1'b0, 0);
      for (int i = 0; i < 10; i++) tick(1'b1, 205, "rej");
      tick(1'b1, 160, "rej199");
      chk("rej199.avg", 32'(avg_out), 199);
      tick(1'b1, 250, "rej");
      tick(1'b1, 205, "rej");
      tick(1'b1, 205, "rej");
      chk("rej.avg205", 32'(avg_out), 205);
      chk("rej.op", 32'(over_pressure), 0);

      // Enter alarm, then hysteresis band
      tick(1'b1, 205, "enter");
      chk("enter.op", 32'(over_pressure), 1);
      for (int i = 0; i < 10; i++) tick(1'b1, 190, "band");
      chk("band.avg190", 32'(avg_out), 190);
      chk("band.op", 32'(over_pressure), 1);

      // Clear with idle gaps: averages of 175
      tick(1'b1, 70, "clr");
      tick(1'b0, 0, "gap");
      tick(1'b0, 0, "gap");
      for (int i = 0; i < 2; i++) begin
         tick(1'b1, 190, "clr");
         tick(1'b0, 0, "gap");
      end
      chk("clr3.op", 32'(over_pressure), 1);
      tick(1'b1, 190, "clr4");
      chk("clr4.avg175", 32'(avg_out), 175);
      chk("clr4.op", 32'(over_pressure), 0);

      // Re-enter alarm, then reset mid-operation with sample_valid high
      for (int i = 0; i < 12; i++) tick(1'b1, 255, "re");
      chk("re.op", 32'(over_pressure), 1);
      do_reset(1'b1, 255);
      for (int i = 0; i < 7; i++) tick(1'b1, 50, "refill");
      chk("refill7.valid", 32'(avg_valid), 0);
      tick(1'b1, 50, "refill8");
      chk("refill8.valid", 32'(avg_valid), 1);
      chk("refill8.avg", 32'(avg_out), 50);
      tick(1'b0, 0, "end");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
